// File: rtl/wide_add_seq.sv
// Word-serial wide add/subtract: one K-bit ripple-carry slice is reused for W
// cycles, LSW first, with the inter-word carry held in a register.
module wide_add_seq #(
    parameter int K = 8,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic [K*W-1:0] a,
    input  logic [K*W-1:0] b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [K*W-1:0] sum,
    output logic           carry_out,
    output logic           overflow
);

    localparam int N  = K * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, next_state;
    logic [CW-1:0]  idx;
    logic           carry;
    logic           sub_q;
    logic [N-1:0]   a_q, b_q, work, next_work;
    logic           accept, last;
    logic [K-1:0]   a_word, b_word, s_word;
    logic [K:0]     chain;

    assign last = (idx == CW'(W - 1));

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (start) begin
                next_state = RUN;
                accept     = 1'b1;
            end
            RUN:  if (last) next_state = DONE;
            DONE: if (start) begin
                next_state = RUN;
                accept     = 1'b1;
            end else begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign a_word = a_q[idx*K +: K];
    assign b_word = b_q[idx*K +: K] ^ {K{sub_q}};

    // The single adder slice: an explicit ripple chain, one full adder per bit.
    always_comb begin
        chain[0] = carry;
        for (int i = 0; i < K; i++) begin
            s_word[i]   = a_word[i] ^ b_word[i] ^ chain[i];
            chain[i+1]  = (a_word[i] & b_word[i]) | (chain[i] & (a_word[i] ^ b_word[i]));
        end
    end

    always_comb begin
        next_work = work;
        next_work[idx*K +: K] = s_word;
    end

    // NOTE: state and datapath use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            work      <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx   <= '0;
            carry <= sub;
        end else if (state == RUN) begin
            work  <= next_work;
            carry <= chain[K];
            if (!last) begin
                idx <= idx + 1'b1;
            end else begin
                // Final word: publish the whole result and flags on the same edge.
                sum       <= next_work;
                carry_out <= chain[K];
                overflow  <= (a_q[N-1] == (b_q[N-1] ^ sub_q)) && (s_word[K-1] != a_q[N-1]);
            end
        end
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed-vector bench for wide_add_seq (K=8, W=4); inputs and samples on the
// falling edge, so each negedge sits midway between two rising edges.
module tb_wide_add_seq;

    localparam int K = 8;
    localparam int W = 4;
    localparam int N = K * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ready, busy, done, carry_out, overflow;
    logic [N-1:0] sum;

    int vectors = 0;
    int miscompares = 0;

    wide_add_seq #(.K(K), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Issue one operation from the current negedge and wait for done.
    // lat = negedges from issue until done is seen (W+1 expected), -1 on timeout.
    task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv,
                         output int lat, output int busy_cycles);
        a = av; b = bv; sub = sv; start = 1'b1;
        lat = -1; busy_cycles = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({ready, busy, done, carry_out, overflow, sum} !== {5'b10000, 32'h0}) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: got rdy=%b bsy=%b dn=%b co=%b ov=%b sum=%h, want 1 0 0 0 0 00000000",
                         i, ready, busy, done, carry_out, overflow, sum);
            end
        end
    endtask

    task automatic test_add_basic();
        int lat, bc;
        do_op(32'h000000FF, 32'h00000001, 1'b0, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow} !== {32'h00000100, 2'b00}) begin
            miscompares++;
            $display("FAIL add_ff_1: got sum=%h co=%b ov=%b, want 00000100 0 0", sum, carry_out, overflow);
        end
        vectors++;
        if (lat !== W + 1) begin
            miscompares++;
            $display("FAIL add_latency: got %0d, want %0d", lat, W + 1);
        end
        vectors++;
        if (bc !== W) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d, want %0d", bc, W);
        end
        vectors++;
        if ({ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL done_state: got rdy=%b bsy=%b, want 1 0", ready, busy);
        end
        @(negedge clk);
        vectors++;
        if ({ready, busy, done, sum} !== {3'b100, 32'h00000100}) begin
            miscompares++;
            $display("FAIL done_one_cycle: got rdy=%b bsy=%b dn=%b sum=%h, want 1 0 0 00000100",
                     ready, busy, done, sum);
        end
    endtask

    task automatic test_add_carry();
        int lat, bc;
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h0, 2'b10, W + 1}) begin
            miscompares++;
            $display("FAIL add_wrap: got sum=%h co=%b ov=%b lat=%0d, want 00000000 1 0 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h80000000, 2'b01, W + 1}) begin
            miscompares++;
            $display("FAIL add_overflow: got sum=%h co=%b ov=%b lat=%0d, want 80000000 0 1 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        do_op(32'h00000005, 32'h00000007, 1'b1, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'hFFFFFFFE, 2'b00, W + 1}) begin
            miscompares++;
            $display("FAIL sub_borrow: got sum=%h co=%b ov=%b lat=%0d, want fffffffe 0 0 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
        do_op(32'h80000000, 32'h00000001, 1'b1, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h7FFFFFFF, 2'b11, W + 1}) begin
            miscompares++;
            $display("FAIL sub_overflow: got sum=%h co=%b ov=%b lat=%0d, want 7fffffff 1 1 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; sub = 1'b0; start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            start = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        end
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h33333333, 2'b00, W + 1}) begin
            miscompares++;
            $display("FAIL ignore_start: got sum=%h co=%b ov=%b lat=%0d, want 33333333 0 0 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
        // Start in the DONE cycle: 0x10 - 0x3.
        a = 32'h00000010; b = 32'h00000003; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        vectors++;
        if ({busy, done, sum} !== {2'b10, 32'h33333333}) begin
            miscompares++;
            $display("FAIL b2b_no_gap: got bsy=%b dn=%b sum=%h, want 1 0 33333333", busy, done, sum);
        end
        lat = -1;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (sum !== 32'h33333333) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_sum_hold: got sum=%h, want 33333333", sum);
            end
        end
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h0000000D, 2'b10, W + 1}) begin
            miscompares++;
            $display("FAIL b2b_sub: got sum=%h co=%b ov=%b lat=%0d, want 0000000d 1 0 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        logic seen_done;
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
        @(negedge clk);                   // past E0
        start = 1'b0;
        @(negedge clk);                   // past E1
        rst_n = 1'b0;                     // sampled at E2
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({ready, busy, done, carry_out, overflow, sum} !== {5'b10000, 32'h0}) begin
            miscompares++;
            $display("FAIL mid_reset_state: got rdy=%b bsy=%b dn=%b co=%b ov=%b sum=%h, want 1 0 0 0 0 00000000",
                     ready, busy, done, carry_out, overflow, sum);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got activity=%b, want 0", seen_done);
        end
        do_op(32'h12345678, 32'h11111111, 1'b0, lat, bc);
        vectors++;
        if ({sum, carry_out, overflow, lat} !== {32'h23456789, 2'b00, W + 1}) begin
            miscompares++;
            $display("FAIL after_reset_add: got sum=%h co=%b ov=%b lat=%0d, want 23456789 0 0 %0d",
                     sum, carry_out, overflow, lat, W + 1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Word-serial wide add/subtract sequencer. It computes an (K·W)-bit sum or difference by driving a single K-bit ripple-carry adder slice for W consecutive cycles, least-significant word first, with the carry held in a register between words. It sits between a requester (start/done handshake) and the team's K-bit adder, trading W cycles of latency for one slice of adder area.

## Interface
- K, default 8: word width; width of the single adder slice.
- W, default 4: number of words; operand width is K·W. Legal range is W ≥ 2.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: synchronous reset, active-low, sampled on the rising edge of clk.
- start  in  1: request a new operation; only accepted while ready=1.
- sub  in  1: operation select, sampled with start. 0 = a+b, 1 = a−b.
- a  in  K·W: operand A, unsigned or two's complement.
- b  in  K·W: operand B.
- ready  out  1: block can accept start (state IDLE or DONE).
- busy  out  1: operation in progress (state RUN).
- done  out  1: one-cycle pulse; sum and flags are valid and held.
- sum  out  K·W: registered result.
- carry_out  out  1: carry out of the MSB word. For sub this is the not-borrow flag (1 = no borrow).
- overflow  out  1: two's-complement overflow of the full-width result.

## Operation
- Datapath: exactly one K-bit adder slice (carry-in, K sum bits, carry-out). No wider adder and no `+` of width > K is permitted.
- Subtract is implemented as a + ~b + 1: B is inverted word-wise and the initial carry is 1. For add, the initial carry is 0.
- State machine states are IDLE, RUN, DONE.
  - IDLE → RUN on start=1; IDLE otherwise.
  - RUN → DONE once the word counter has reached W−1; otherwise stay in RUN and increment the counter.
  - DONE → RUN on start=1 (back-to-back accepted); DONE → IDLE otherwise.
- On accept, the block:
  - latches a, b and sub into internal operand registers;
  - clears the word counter to 0;
  - loads the carry register with sub.
- Each RUN cycle:
  - the slice adds a_word[idx] + (b_word[idx] ^ {K{sub}}) + carry;
  - the slice result is written to work register word idx;
  - the slice carry-out is written to the carry register.
- On the RUN→DONE edge, all outputs are loaded atomically:
  - sum ← full work value (including the final word being written on that edge);
  - carry_out ← final carry;
  - overflow ← (A_msb == B'_msb) && (S_msb != A_msb), where B' is the inverted B when sub=1.
- sum, carry_out and overflow hold their last values through IDLE and through any following RUN, until the next RUN→DONE edge.
- start is ignored while in RUN. Changes to a, b and sub after the accept edge have no effect on the current operation.

## Timing
- ready = (state==IDLE) | (state==DONE), combinational from state. busy = (state==RUN).
- done is registered and is high exactly while state==DONE.
- Latency: with the accept edge as E0, word i is captured at edge E(i+1).
  - done is high from E(W) to E(W+1).
  - busy is high from E0 to E(W).
- Throughput: with start held high, one result every W+1 cycles.
- Reset values after a rising edge with rst_n=0:
  - state IDLE, ready=1, busy=0, done=0;
  - sum=0, carry_out=0, overflow=0;
  - counter, carry and operand registers cleared.
- Reset asserted mid-RUN aborts the operation: no done pulse is produced and the outputs go to their reset values.
- rst_n=0 takes priority over start on the same edge.
- Counter wrap: the counter never exceeds W−1. It is cleared only on accept.

## Test plan
- Reset with K=8, W=4: hold rst_n=0 for 2 cycles, then release with start=0 → ready=1, busy=0, done=0, sum=0x00000000, carry_out=0, overflow=0, held for 10 cycles.
- Add 0x000000FF + 0x00000001 → sum=0x00000100, carry_out=0, overflow=0. busy is high for exactly 4 cycles, and done is high for exactly one cycle starting at E4.
- Add 0xFFFFFFFF + 0x00000001 → sum=0, carry_out=1, overflow=0. Then add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, carry_out=0, overflow=1.
- Sub 0x00000005 − 0x00000007 → sum=0xFFFFFFFE, carry_out=0, overflow=0. Then sub 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, carry_out=1, overflow=1.
- Pulse start and randomize a/b/sub every cycle during RUN → the result still equals the operation on the operands latched at E0, and the extra starts are ignored. Then assert start in the DONE cycle → the next operation begins with no IDLE gap, and sum holds its old value until that operation's done.
- Assert rst_n=0 at E2 of an add → at the next edge all outputs equal their reset values, no done appears within 10 cycles, and a following add of 0x12345678 + 0x11111111 gives sum=0x23456789.
